bf16_cvt_arbiter: RTL and testbench
===================================

Name: bf16_cvt_arbiter

Overview:
- Shares one BF16-to-FP32 conversion datapath between NUM_REQ requesters.
- Round-robin arbitration; valid/ready handshakes on every request port and on the single response port.
- One registered response stage tagged with the requester ID.
- Sticky invalid flag and a wrapping conversion counter for status readback.
- Sits between the accelerator's lane front-ends and the FP32 accumulate path.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, $clog2(NUM_REQ), width of the requester ID tag.
- CNT_W, 16, width of the conversion counter.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_data  in  16*NUM_REQ  BF16 operands; requester i uses bits [16*i+15:16*i].
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  downstream accept.
- rsp_data  out  32  FP32 result.
- rsp_id  out  ID_W  index of the requester that produced the response.
- rsp_invalid  out  1  response came from a NaN input.
- flag_clr  in  1  clears invalid_sticky.
- invalid_sticky  out  1  set by any accepted NaN.
- conv_count  out  CNT_W  count of accepted requests.

Behaviour:
- Reset: one clk edge with reset=1 forces:
  - rsp_valid=0, rsp_data=0, rsp_id=0, rsp_invalid=0.
  - invalid_sticky=0, conv_count=0, RR pointer=0, state=EMPTY.
  - req_ready is combinational: 0 while no request is valid.
  - Reset mid-stall discards the held response. No request is accepted in the reset cycle, so req_ready=0 while reset=1.
- State machine on the response register:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY when rsp_ready=1 and no accept.
  - FULL -> FULL when rsp_ready=0 (hold), or when rsp_ready=1 with accept (back-to-back).
- Accept enable: can_accept = (state==EMPTY) | rsp_ready. This is a combinational pass-through of rsp_ready; no skid buffer.
- Arbitration:
  - Grant goes to the first i with req_valid[i]=1, searching ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1.
  - req_ready[g] = can_accept & req_valid[g]. All other req_ready bits are 0.
  - Accept = handshake on granted port.
  - On accept, ptr <= (g+1) mod NUM_REQ. Without an accept, ptr holds.
  - With can_accept=0, ptr holds and the grant may change as requests change. Requesters must hold valid/data until ready.
- Conversion, combinational, registered on accept:
  - exp==8'hFF and man!=0 (NaN): rsp_data=32'h7FC00000, rsp_invalid=1.
  - Otherwise rsp_data={bf16,16'h0000}, rsp_invalid=0. This covers zero, inf, normal and subnormal (sign kept).
  - rsp_id <= g.
- Latency and throughput:
  - Latency is 1 cycle: rsp_valid rises on the edge that accepts.
  - Throughput is 1 per cycle when rsp_ready=1.
  - rsp_data, rsp_id and rsp_invalid are stable while rsp_valid=1 and rsp_ready=0.
- Sticky flag:
  - invalid_sticky <= 1 on accept of a NaN.
  - Else cleared by flag_clr.
  - Simultaneous set and clear: set wins.
- Counter: conv_count increments by 1 on each accept and wraps from 2^CNT_W-1 to 0.
- Overflow, underflow and inexact flags do not exist for this conversion and are not produced.

Test Plan:
- Reset, then req_valid[2]=1, data 16'h3F80, rsp_ready=1 -> next cycle: rsp_valid=1, rsp_data=32'h3F800000, rsp_id=2, rsp_invalid=0, conv_count=1, ptr=3.
- All four requesters valid continuously, rsp_ready=1, ptr=0 -> grants 0,1,2,3,0 on consecutive cycles, one response per cycle, rsp_id sequence 0,1,2,3,0.
- Req0 data 16'h7FC1 (NaN) -> rsp_data=32'h7FC00000, rsp_invalid=1, invalid_sticky=1. Next, assert flag_clr on the same cycle a second NaN is accepted -> invalid_sticky stays 1. flag_clr alone next cycle -> 0.
- Backpressure: response FULL, rsp_ready=0 for 3 cycles with req1 valid -> req_ready=0, rsp_data/rsp_id held, ptr unchanged. rsp_ready=1 -> req1 accepted the same cycle, back-to-back FULL.
- Specials: 16'hFF80 -> 32'hFF800000; 16'h8000 -> 32'h80000000; 16'h0001 -> 32'h00010000, all rsp_invalid=0.
- Preload 65535 accepts (or force conv_count=16'hFFFF), then one more accept -> conv_count=0. Assert reset while FULL -> rsp_valid=0 next cycle, count=0.

Source files
------------

// File: rtl/bf16_cvt_arbiter.sv
// Round-robin arbiter sharing one BF16->FP32 converter; result registered with requester ID (1-cycle latency).
// Backpressure: rsp_ready passes straight through to req_ready; a held response blocks new grants.
module bf16_cvt_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [16*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_data,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  rsp_invalid,
  input  logic                  flag_clr,
  output logic                  invalid_sticky,
  output logic [CNT_W-1:0]      conv_count
);

  typedef enum logic {EMPTY, FULL} state_t;

  localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic              rsp_invalid_q, rsp_invalid_d;
  logic              sticky_q, sticky_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              grant_vld;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W:0]     cand;
  logic              can_accept;
  logic              accept;
  logic [15:0]       sel_dat;
  logic              sel_nan;
  logic [31:0]       cvt_dat;

  // Rotating priority search starting at ptr_q, wrapping modulo NUM_REQ.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + k[ID_W:0];
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!grant_vld && req_valid[cand[ID_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_id  = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    can_accept = !reset && ((state_q == EMPTY) || rsp_ready);
    accept     = grant_vld && can_accept;
    req_ready  = '0;
    if (accept) req_ready[grant_id] = 1'b1;
  end

  // NaN collapses to the canonical quiet NaN; everything else is a plain widen.
  always_comb begin
    sel_dat = req_data[{grant_id, 4'b0000} +: 16];
    sel_nan = (sel_dat[14:7] == 8'hFF) && (sel_dat[6:0] != 7'd0);
    cvt_dat = sel_nan ? 32'h7FC0_0000 : {sel_dat, 16'h0000};
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    rsp_data_d    = rsp_data_q;
    rsp_id_d      = rsp_id_q;
    rsp_invalid_d = rsp_invalid_q;
    sticky_d      = sticky_q;
    cnt_d         = cnt_q;
    if (accept) begin
      state_d       = FULL;
      ptr_d         = (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);
      rsp_data_d    = cvt_dat;
      rsp_id_d      = grant_id;
      rsp_invalid_d = sel_nan;
      cnt_d         = cnt_q + CNT_W'(1);
    end else if (state_q == FULL && rsp_ready) begin
      state_d = EMPTY;
    end
    if (accept && sel_nan) sticky_d = 1'b1;
    else if (flag_clr)     sticky_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= EMPTY;
      ptr_q         <= '0;
      rsp_data_q    <= '0;
      rsp_id_q      <= '0;
      rsp_invalid_q <= 1'b0;
      sticky_q      <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      rsp_data_q    <= rsp_data_d;
      rsp_id_q      <= rsp_id_d;
      rsp_invalid_q <= rsp_invalid_d;
      sticky_q      <= sticky_d;
      cnt_q         <= cnt_d;
    end
  end

  assign rsp_valid      = (state_q == FULL);
  assign rsp_data       = rsp_data_q;
  assign rsp_id         = rsp_id_q;
  assign rsp_invalid    = rsp_invalid_q;
  assign invalid_sticky = sticky_q;
  assign conv_count     = cnt_q;

endmodule

// File: tb/tb_bf16_cvt_arbiter.sv
// Randomised and directed bench for bf16_cvt_arbiter against a cycle-level reference model.
module tb_bf16_cvt_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int CNT_W   = 16;

  logic                  clk;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid;
  logic [16*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_data;
  logic [ID_W-1:0]       rsp_id;
  logic                  rsp_invalid;
  logic                  flag_clr;
  logic                  invalid_sticky;
  logic [CNT_W-1:0]      conv_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_ptr;
  bit          m_full;
  logic [31:0] m_data;
  int          m_id;
  bit          m_inv;
  bit          m_sticky;
  logic [15:0] m_cnt;

  bf16_cvt_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_invalid(rsp_invalid),
    .flag_clr(flag_clr), .invalid_sticky(invalid_sticky), .conv_count(conv_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit is_nan(logic [15:0] b);
    return (b[14:7] == 8'hFF) && (b[6:0] != 7'd0);
  endfunction

  function automatic logic [31:0] ref_cvt(logic [15:0] b);
    if (is_nan(b)) return 32'h7FC0_0000;
    return {b, 16'h0000};
  endfunction

  function automatic int exp_grant();
    for (int k = 0; k < NUM_REQ; k++) begin
      int i;
      i = (m_ptr + k) % NUM_REQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [NUM_REQ-1:0] exp_ready();
    logic [NUM_REQ-1:0] r;
    int g;
    r = '0;
    g = exp_grant();
    if (!reset && (!m_full || rsp_ready) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic logic [15:0] rand_bf16();
    logic [15:0] v;
    v = 16'($urandom);
    case ($urandom_range(0, 5))
      0: v[14:7] = 8'hFF;
      1: v[14:7] = 8'h00;
      default: ;
    endcase
    return v;
  endfunction

  // Advance one clock edge and update the model from the inputs presented before it.
  task automatic tick();
    int          g;
    bit          acc;
    logic [15:0] b;
    g   = exp_grant();
    acc = !reset && (!m_full || rsp_ready) && (g >= 0);
    b   = (g >= 0) ? req_data[16*g +: 16] : 16'h0;
    @(posedge clk);
    if (reset) begin
      m_ptr = 0; m_full = 0; m_data = 0; m_id = 0; m_inv = 0; m_sticky = 0; m_cnt = 0;
    end else begin
      if (acc) begin
        m_full = 1; m_data = ref_cvt(b); m_id = g; m_inv = is_nan(b);
        m_ptr = (g + 1) % NUM_REQ; m_cnt = m_cnt + 16'd1;
      end else if (m_full && rsp_ready) begin
        m_full = 0;
      end
      if (acc && is_nan(b)) m_sticky = 1;
      else if (flag_clr)    m_sticky = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; flag_clr = 1'b0; rsp_ready = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '1; req_data = {4{16'h3F80}}; rsp_ready = 1'b1; flag_clr = 1'b0;
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b exp 0000", req_ready); end
    tick();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b exp 0", rsp_valid); end
    n_checks++; if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_data: got %h exp 0", rsp_data); end
    n_checks++; if (rsp_id !== 2'd0 || rsp_invalid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_id_inv: got %0d/%b exp 0/0", rsp_id, rsp_invalid); end
    n_checks++; if (invalid_sticky !== 1'b0 || conv_count !== 16'd0) begin n_fail++; $display("FAIL reset_status: got %b/%0d exp 0/0", invalid_sticky, conv_count); end
    reset = 1'b0; req_valid = '0;
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0100; req_data = 64'h0; req_data[47:32] = 16'h3F80; rsp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b exp 0100", req_ready); end
    tick();
    req_valid = '0;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h3F80_0000) begin n_fail++; $display("FAIL single_data: got %b/%h exp 1/3f800000", rsp_valid, rsp_data); end
    n_checks++; if (rsp_id !== 2'd2 || rsp_invalid !== 1'b0 || conv_count !== 16'd1) begin n_fail++; $display("FAIL single_tag: got id%0d inv%b cnt%0d exp 2/0/1", rsp_id, rsp_invalid, conv_count); end
    req_valid = 4'b1111;
    #1;
    n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL single_ptr: got %b exp 1000", req_ready); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_round_robin();
    int seq[5] = '{0, 1, 2, 3, 0};
    do_reset();
    rsp_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      req_valid = '1;
      for (int i = 0; i < NUM_REQ; i++) req_data[16*i +: 16] = rand_bf16();
      tick();
      n_checks++;
      if (rsp_valid !== 1'b1 || int'(rsp_id) != seq[c] || rsp_data !== m_data) begin
        n_fail++; $display("FAIL rr_cycle%0d: got v%b id%0d %h exp 1/%0d/%h", c, rsp_valid, rsp_id, rsp_data, seq[c], m_data);
      end
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_nan_sticky();
    do_reset();
    req_valid = 4'b0001; req_data[15:0] = 16'h7FC1;
    tick();
    n_checks++; if (rsp_data !== 32'h7FC0_0000 || rsp_invalid !== 1'b1 || invalid_sticky !== 1'b1) begin n_fail++; $display("FAIL nan_first: got %h inv%b st%b exp 7fc00000/1/1", rsp_data, rsp_invalid, invalid_sticky); end
    req_data[15:0] = 16'hFF81; flag_clr = 1'b1;
    tick();
    n_checks++; if (invalid_sticky !== 1'b1 || rsp_invalid !== 1'b1) begin n_fail++; $display("FAIL nan_set_wins: got st%b inv%b exp 1/1", invalid_sticky, rsp_invalid); end
    req_valid = '0;
    tick();
    n_checks++; if (invalid_sticky !== 1'b0) begin n_fail++; $display("FAIL nan_clear: got %b exp 0", invalid_sticky); end
    flag_clr = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] held_data;
    logic [ID_W-1:0] held_id;
    do_reset();
    req_valid = 4'b0001; req_data[15:0] = rand_bf16(); rsp_ready = 1'b0;
    tick();
    held_data = rsp_data; held_id = rsp_id;
    req_valid = 4'b0010; req_data[31:16] = rand_bf16();
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready%0d: got %b exp 0000", c, req_ready); end
      tick();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== held_data || rsp_id !== held_id || rsp_data !== m_data) begin
        n_fail++; $display("FAIL bp_hold%0d: got v%b %h id%0d exp 1/%h/%0d", c, rsp_valid, rsp_data, rsp_id, m_data, m_id);
      end
    end
    rsp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_release_ready: got %b exp 0010", req_ready); end
    tick();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== ref_cvt(req_data[31:16])) begin n_fail++; $display("FAIL bp_b2b: got v%b id%0d %h exp 1/1/%h", rsp_valid, rsp_id, rsp_data, ref_cvt(req_data[31:16])); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_specials();
    logic [15:0] ins[5]  = '{16'hFF80, 16'h8000, 16'h0001, 16'h7F80, 16'h0000};
    logic [31:0] outs[5] = '{32'hFF80_0000, 32'h8000_0000, 32'h0001_0000, 32'h7F80_0000, 32'h0000_0000};
    rsp_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      int p;
      p = $urandom_range(0, NUM_REQ-1);
      req_valid = '0; req_valid[p] = 1'b1; req_data[16*p +: 16] = ins[t];
      tick();
      n_checks++;
      if (rsp_data !== outs[t] || rsp_invalid !== 1'b0 || int'(rsp_id) != p) begin
        n_fail++; $display("FAIL special_%h: got %h inv%b id%0d exp %h/0/%0d", ins[t], rsp_data, rsp_invalid, rsp_id, outs[t], p);
      end
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_random();
    int errs = 0;
    for (int c = 0; c < 400; c++) begin
      req_valid = NUM_REQ'($urandom);
      for (int i = 0; i < NUM_REQ; i++) req_data[16*i +: 16] = rand_bf16();
      rsp_ready = ($urandom_range(0, 3) != 0);
      flag_clr  = ($urandom_range(0, 7) == 0);
      #1;
      n_checks++;
      if (req_ready !== exp_ready()) begin n_fail++; errs++; if (errs < 10) $display("FAIL rand_ready c%0d: got %b exp %b", c, req_ready, exp_ready()); end
      tick();
      n_checks++;
      if (rsp_valid !== m_full || (m_full && (rsp_data !== m_data || int'(rsp_id) != m_id || rsp_invalid !== m_inv))
          || invalid_sticky !== m_sticky || conv_count !== m_cnt) begin
        n_fail++; errs++;
        if (errs < 10) $display("FAIL rand_out c%0d: got v%b %h id%0d inv%b st%b cnt%0d exp %b/%h/%0d/%b/%b/%0d",
                                c, rsp_valid, rsp_data, rsp_id, rsp_invalid, invalid_sticky, conv_count,
                                m_full, m_data, m_id, m_inv, m_sticky, m_cnt);
      end
    end
    req_valid = '0; flag_clr = 1'b0; rsp_ready = 1'b1;
    tick();
  endtask

  task automatic test_count_wrap();
    do_reset();
    req_valid = 4'b0001; req_data[15:0] = 16'h4000; rsp_ready = 1'b1;
    for (int c = 0; c < 65535; c++) tick();
    n_checks++; if (conv_count !== 16'hFFFF || conv_count !== m_cnt) begin n_fail++; $display("FAIL cnt_max: got %h exp ffff", conv_count); end
    tick();
    n_checks++; if (conv_count !== 16'h0000) begin n_fail++; $display("FAIL cnt_wrap: got %h exp 0000", conv_count); end
    rsp_ready = 1'b0;
    tick();
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rst_full_pre: got %b exp 1", rsp_valid); end
    reset = 1'b1; rsp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_full_ready: got %b exp 0000", req_ready); end
    tick();
    reset = 1'b0; req_valid = '0;
    n_checks++; if (rsp_valid !== 1'b0 || conv_count !== 16'd0 || rsp_data !== 32'h0) begin n_fail++; $display("FAIL rst_full: got v%b cnt%0d %h exp 0/0/0", rsp_valid, conv_count, rsp_data); end
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b1; flag_clr = 1'b0;
    m_ptr = 0; m_full = 0; m_data = 0; m_id = 0; m_inv = 0; m_sticky = 0; m_cnt = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_nan_sticky();
    test_backpressure();
    test_specials();
    test_random();
    test_count_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
